vp_lvp_table: RTL and testbench
===============================

Name: vp_lvp_table

Overview:
- Parametrised last-value predictor table for the value-prediction (VP_ENABLED) path; next generation of the fixed two-lane vp_pkt_t flow.
- Lane count, table depth, tag width and confidence width are all parameters.
- Decode-side lookup per lane returns predicted value, confidence and a use-qualified valid; commit-side training per lane updates the value, tag and a saturating confidence counter, and flags confident mispredictions.
- Sits between dec (lookup at decode) and the commit/writeback stage (training).

Parameters:
- LANES, 2, number of independent lookup and train lanes.
- DEPTH, 64, table entries; must be a power of two, at least 4.
- TAG_WIDTH, 8, partial PC tag bits per entry.
- CONF_WIDTH, 3, confidence counter width; matches P_CONF_WIDTH.
- CONF_THRESH, 4, minimum confidence for pred_valid; must satisfy 1 ≤ CONF_THRESH ≤ 2^CONF_WIDTH-1.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous, active-low. One clock; no other clock or reset.
- clear  in  1  synchronous invalidate of all entries (fence.i / debug).
- lkp_valid  in  LANES  lookup request per lane.
- lkp_pc  in  LANES x 32  instruction PC per lane; bit 0 ignored.
- pred_valid  out  LANES  confident tag hit.
- pred_hit  out  LANES  tag hit regardless of confidence.
- pred_value  out  LANES x 32  predicted result.
- pred_conf  out  LANES x CONF_WIDTH  entry confidence.
- trn_valid  in  LANES  train request per lane; lane index is program order, higher = younger.
- trn_pc  in  LANES x 32  PC of the committing instruction.
- trn_actual  in  LANES x 32  actual result.
- trn_misp  out  LANES  the entry was confident and its value differed from trn_actual.

Behaviour:
- Indexing:
  - IW = clog2(DEPTH).
  - Index = pc[IW:1].
  - Tag = pc[IW+TAG_WIDTH:IW+1].
- Entry contents: valid, tag, value[31:0], conf[CONF_WIDTH-1:0]. Only the valid bits are reset; tag, value and conf are not reset.
- Reset (rst_l low, async):
  - All entry valid bits cleared.
  - All outputs (pred_valid, pred_hit, pred_value, pred_conf, trn_misp) are 0.
- Lookup, registered, 1-cycle latency:
  - Request in cycle t produces outputs in t+1.
  - pred_hit = lkp_valid & entry.valid & tag match.
  - pred_valid = pred_hit & (conf ≥ CONF_THRESH).
  - pred_value and pred_conf are 0 when pred_hit is 0.
  - Outputs are held 0 in any cycle after a cycle with lkp_valid low.
- Training, written at the clock edge ending cycle t:
  - Hit, value equal: conf = min(conf+1, 2^CONF_WIDTH-1).
  - Hit, value unequal: value ← actual, conf ← 0; trn_misp = 1 in t+1 if the old conf ≥ CONF_THRESH.
  - Miss or invalid entry: allocate; valid ← 1, tag, value ← actual, conf ← 0; trn_misp = 0.
  - trn_misp is registered, 1-cycle latency, and is 0 for lanes not training.
- Simultaneous events:
  - Lookup and train to the same index in the same cycle: the lookup sees pre-train contents (no bypass). A lookup in t+1 sees the update.
  - Multiple train lanes to the same index: only the youngest lane writes. Older lanes to that index produce trn_misp = 0 and no update.
  - clear together with train: clear wins; all valid bits are 0 next cycle.
  - clear together with lookup: the lookup still returns pre-clear contents.
- Arithmetic: all compares are full 32-bit; the confidence counter saturates at both ends and never wraps.
- Reset asserted mid-operation: in-flight registered outputs are forced to 0 immediately. After reset, the first lookup misses.

Optional Feature:
- Macro: VP_STRIDE_EN.
- With the macro defined:
  - Each entry adds stride[31:0].
  - Prediction = value + stride, mod 2^32.
  - Train hit compares actual with value+stride. On match, conf increments. On mismatch, stride ← actual − value and conf ← 0.
  - value ← actual on every train hit.
  - Allocation sets stride ← 0.
  - trn_misp rules are unchanged, using the strided prediction.
- Without it: pure last-value behaviour as above; no stride storage.

Decomposition:
- swerv_types gains vp_lane_pkt_t {valid, hit, value[31:0], conf[`P_CONF_WIDTH-1:0]} so that dec/exu carry per-lane packets for any LANES.
- vp_pkt_t is retained for the legacy two-lane path.
- Sub-module vp_conf_ctr: combinational next-confidence logic plus the threshold compare. It is instantiated once per train lane and once per lookup lane.

Test Plan:
- Allocation and confidence build-up: train pc 0x100 actual 0x55 five times, then look up 0x100.
  - Required: pred_hit=1, pred_valid=1, pred_value=0x55, pred_conf=4.
- Confident mispredict: continue from the previous case and train 0x100 actual 0x66.
  - Required: trn_misp=1 next cycle.
  - A following lookup gives pred_hit=1, pred_valid=0, value=0x66, conf=0.
- Saturation: train 0x200 actual 7 twelve times.
  - Required: pred_conf=7; no wrap.
- Dual-lane same index: lane0 (0x100, 1) and lane1 (0x100, 2) in one cycle.
  - Required: entry value=2, conf=0, both trn_misp=0.
- Tag alias: allocate 0x100, then look up 0x180 (same index, different tag).
  - Required: pred_hit=0, pred_valid=0, pred_value=0.
- Clear and reset: build conf=7 at 0x300, then pulse clear.
  - Required: the next lookup misses.
  - Separately, assert rst_l low mid-lookup: outputs go to 0 asynchronously, and the next lookup after reset misses.

Source files
------------

// File: rtl/vp_lvp_table_pkg.sv
// Shared types and constants for the last-value predictor table.
// The optional stride predictor is enabled with the VP_STRIDE_EN macro.
package vp_lvp_table_pkg;

  localparam int PC_W         = 32;
  localparam int P_CONF_WIDTH = 3;

  // Per-lane prediction packet carried by dec/exu for any lane count.
  typedef struct packed {
    logic                    valid;
    logic                    hit;
    logic [PC_W-1:0]         value;
    logic [P_CONF_WIDTH-1:0] conf;
  } vp_lane_pkt_t;

  // Legacy fixed two-lane packet, kept for the old path.
  typedef struct packed {
    vp_lane_pkt_t [1:0] lane;
  } vp_pkt_t;

endpackage

// File: rtl/vp_lvp_table_if.sv
// Lookup / train bus between dec, commit and the value-predictor table.
interface vp_lvp_table_if #(
  parameter int LANES      = 2,
  parameter int CONF_WIDTH = 3
);
  import vp_lvp_table_pkg::*;

  logic                                clear;
  logic [LANES-1:0]                    lkp_valid;
  logic [LANES-1:0][PC_W-1:0]          lkp_pc;
  logic [LANES-1:0]                    pred_valid;
  logic [LANES-1:0]                    pred_hit;
  logic [LANES-1:0][PC_W-1:0]          pred_value;
  logic [LANES-1:0][CONF_WIDTH-1:0]    pred_conf;
  logic [LANES-1:0]                    trn_valid;
  logic [LANES-1:0][PC_W-1:0]          trn_pc;
  logic [LANES-1:0][PC_W-1:0]          trn_actual;
  logic [LANES-1:0]                    trn_misp;

  modport master (
    output clear, lkp_valid, lkp_pc, trn_valid, trn_pc, trn_actual,
    input  pred_valid, pred_hit, pred_value, pred_conf, trn_misp
  );

  modport slave (
    input  clear, lkp_valid, lkp_pc, trn_valid, trn_pc, trn_actual,
    output pred_valid, pred_hit, pred_value, pred_conf, trn_misp
  );

endinterface

// File: rtl/vp_lvp_table_conf_ctr.sv
// Saturating confidence next-state and threshold compare, one per lane.
module vp_conf_ctr #(
  parameter int CONF_WIDTH  = 3,
  parameter int CONF_THRESH = 4
) (
  input  logic [CONF_WIDTH-1:0] i_conf,
  input  logic                  i_inc,
  input  logic                  i_clr,
  output logic [CONF_WIDTH-1:0] o_conf_nxt,
  output logic                  o_confident
);

  localparam logic [CONF_WIDTH-1:0] SAT = '1;
  localparam logic [CONF_WIDTH-1:0] THR = CONF_WIDTH'(CONF_THRESH);

  // Clear dominates; increment stops at all-ones so the counter never wraps.
  always_comb begin
    o_conf_nxt = i_conf;
    if (i_clr)
      o_conf_nxt = '0;
    else if (i_inc && (i_conf != SAT))
      o_conf_nxt = i_conf + 1'b1;
  end

  assign o_confident = (i_conf >= THR);

endmodule

// File: rtl/vp_lvp_table.sv
// Multi-lane last-value predictor table: registered decode lookup, commit training.
// Define VP_STRIDE_EN to add a per-entry stride (prediction = value + stride).
module vp_lvp_table
  import vp_lvp_table_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int DEPTH       = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int CONF_WIDTH  = 3,
  parameter int CONF_THRESH = 4
) (
  input  logic            clk,
  input  logic            rst_l,
  vp_lvp_table_if.slave   bus
);

  localparam int IW = $clog2(DEPTH);

  // Only the valid bits are reset; payload is qualified by them.
  logic [DEPTH-1:0]      r_vld;
  logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
  logic [PC_W-1:0]       r_val  [DEPTH];
  logic [CONF_WIDTH-1:0] r_conf [DEPTH];
`ifdef VP_STRIDE_EN
  logic [PC_W-1:0]       r_str  [DEPTH];
`endif

  logic [LANES-1:0]                 r_pred_valid;
  logic [LANES-1:0]                 r_pred_hit;
  logic [LANES-1:0][PC_W-1:0]       r_pred_value;
  logic [LANES-1:0][CONF_WIDTH-1:0] r_pred_conf;
  logic [LANES-1:0]                 r_misp;

  logic [LANES-1:0][IW-1:0]         w_lidx;
  logic [LANES-1:0][TAG_WIDTH-1:0]  w_ltag;
  logic [LANES-1:0]                 w_lhit;
  logic [LANES-1:0]                 w_lok;
  logic [LANES-1:0][CONF_WIDTH-1:0] w_lconf;
  logic [LANES-1:0][PC_W-1:0]       w_lpred;

  logic [LANES-1:0][IW-1:0]         w_tidx;
  logic [LANES-1:0][TAG_WIDTH-1:0]  w_ttag;
  logic [LANES-1:0]                 w_thit;
  logic [LANES-1:0][PC_W-1:0]       w_tpred;
  logic [LANES-1:0]                 w_teq;
  logic [LANES-1:0]                 w_tok;
  logic [LANES-1:0][CONF_WIDTH-1:0] w_tconf_nxt;
  logic [LANES-1:0]                 w_twe;
  logic [LANES-1:0]                 w_unused_pc;

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    // Bit 0 and the bits above the tag do not take part in indexing.
    assign w_unused_pc[g] = ^{bus.lkp_pc[g], bus.trn_pc[g]};

    assign w_lidx[g] = bus.lkp_pc[g][IW:1];
    assign w_ltag[g] = bus.lkp_pc[g][IW+TAG_WIDTH:IW+1];
    assign w_lhit[g] = bus.lkp_valid[g] & r_vld[w_lidx[g]] &
                       (r_tag[w_lidx[g]] == w_ltag[g]);

    assign w_tidx[g] = bus.trn_pc[g][IW:1];
    assign w_ttag[g] = bus.trn_pc[g][IW+TAG_WIDTH:IW+1];
    assign w_thit[g] = r_vld[w_tidx[g]] & (r_tag[w_tidx[g]] == w_ttag[g]);
    assign w_teq[g]  = (w_tpred[g] == bus.trn_actual[g]);

`ifdef VP_STRIDE_EN
    assign w_lpred[g] = r_val[w_lidx[g]] + r_str[w_lidx[g]];
    assign w_tpred[g] = r_val[w_tidx[g]] + r_str[w_tidx[g]];
`else
    assign w_lpred[g] = r_val[w_lidx[g]];
    assign w_tpred[g] = r_val[w_tidx[g]];
`endif

    // Lookup side only needs the held count and the threshold compare.
    vp_conf_ctr #(
      .CONF_WIDTH  (CONF_WIDTH),
      .CONF_THRESH (CONF_THRESH)
    ) u_lkp_ctr (
      .i_conf      (r_conf[w_lidx[g]]),
      .i_inc       (1'b0),
      .i_clr       (1'b0),
      .o_conf_nxt  (w_lconf[g]),
      .o_confident (w_lok[g])
    );

    // Anything other than a correct hit (mismatch or allocation) restarts at 0.
    vp_conf_ctr #(
      .CONF_WIDTH  (CONF_WIDTH),
      .CONF_THRESH (CONF_THRESH)
    ) u_trn_ctr (
      .i_conf      (r_conf[w_tidx[g]]),
      .i_inc       (w_thit[g] & w_teq[g]),
      .i_clr       (~(w_thit[g] & w_teq[g])),
      .o_conf_nxt  (w_tconf_nxt[g]),
      .o_confident (w_tok[g])
    );
  end

  // Youngest lane wins a shared index; older lanes are silently dropped.
  always_comb begin
    w_twe = bus.trn_valid;
    for (int l = 0; l < LANES; l++) begin
      for (int k = l + 1; k < LANES; k++) begin
        if (bus.trn_valid[k] && (w_tidx[k] == w_tidx[l]))
          w_twe[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld <= '0;
    end else if (bus.clear) begin
      r_vld <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (w_twe[l])
          r_vld[w_tidx[l]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_twe[l]) begin
        r_tag[w_tidx[l]]  <= w_ttag[l];
        r_val[w_tidx[l]]  <= bus.trn_actual[l];
        r_conf[w_tidx[l]] <= w_tconf_nxt[l];
`ifdef VP_STRIDE_EN
        if (!w_thit[l])
          r_str[w_tidx[l]] <= '0;
        else if (!w_teq[l])
          r_str[w_tidx[l]] <= bus.trn_actual[l] - r_val[w_tidx[l]];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_pred_valid <= '0;
      r_pred_hit   <= '0;
      r_pred_value <= '0;
      r_pred_conf  <= '0;
      r_misp       <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_pred_hit[l]   <= w_lhit[l];
        r_pred_valid[l] <= w_lhit[l] & w_lok[l];
        r_pred_value[l] <= w_lhit[l] ? w_lpred[l] : '0;
        r_pred_conf[l]  <= w_lhit[l] ? w_lconf[l] : '0;
        r_misp[l]       <= w_twe[l] & w_thit[l] & ~w_teq[l] & w_tok[l];
      end
    end
  end

  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_hit   = r_pred_hit;
  assign bus.pred_value = r_pred_value;
  assign bus.pred_conf  = r_pred_conf;
  assign bus.trn_misp   = r_misp;

endmodule

// File: tb/tb_vp_lvp_table.sv
// Bench for vp_lvp_table: directed vector table, reset sequence, randomized model check.
module tb_vp_lvp_table;

  localparam int LANES       = 2;
  localparam int DEPTH       = 64;
  localparam int TAG_WIDTH   = 8;
  localparam int CONF_WIDTH  = 3;
  localparam int CONF_THRESH = 4;
  localparam int MAXC        = (1 << CONF_WIDTH) - 1;

`ifdef VP_STRIDE_EN
  localparam bit          STRIDE = 1'b1;
  localparam logic [31:0] E8V    = 32'h77;
  localparam logic [31:0] E10V   = 32'hFFFF_FF9E;
  localparam logic [2:0]  E12C   = 3'd0;
`else
  localparam bit          STRIDE = 1'b0;
  localparam logic [31:0] E8V    = 32'h66;
  localparam logic [31:0] E10V   = 32'h2;
  localparam logic [2:0]  E12C   = 3'd1;
`endif

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  vp_lvp_table_if #(.LANES(LANES), .CONF_WIDTH(CONF_WIDTH)) bus ();

  vp_lvp_table #(
    .LANES(LANES), .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH),
    .CONF_WIDTH(CONF_WIDTH), .CONF_THRESH(CONF_THRESH)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  lv;
    logic [31:0] lp0, lp1;
    logic [1:0]  tv;
    logic [31:0] tp0, ta0, tp1, ta1;
    logic        clr;
    logic [1:0]  eh, epv;
    logic [31:0] ev0;
    logic [2:0]  ec0;
    logic [31:0] ev1;
    logic [2:0]  ec1;
    logic [1:0]  em;
  } vec_t;

  vec_t vecs[$];

  // Reference table: plain arrays indexed by the PC slice arithmetic.
  bit          m_vld  [DEPTH];
  int unsigned m_tag  [DEPTH];
  logic [31:0] m_val  [DEPTH];
  logic [31:0] m_str  [DEPTH];
  int          m_conf [DEPTH];

  logic [1:0]  x_hit, x_pv, x_misp;
  logic [31:0] x_val  [LANES];
  logic [2:0]  x_conf [LANES];

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> 1) % DEPTH;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> ($clog2(DEPTH) + 1)) % (1 << TAG_WIDTH);
  endfunction

  function automatic vec_t mk(logic [1:0] lv, logic [31:0] lp0, lp1,
                              logic [1:0] tv, logic [31:0] tp0, ta0, tp1, ta1,
                              logic clr, logic [1:0] eh, epv,
                              logic [31:0] ev0, logic [2:0] ec0,
                              logic [31:0] ev1, logic [2:0] ec1, logic [1:0] em);
    vec_t v;
    v.lv = lv; v.lp0 = lp0; v.lp1 = lp1;
    v.tv = tv; v.tp0 = tp0; v.ta0 = ta0; v.tp1 = tp1; v.ta1 = ta1;
    v.clr = clr; v.eh = eh; v.epv = epv;
    v.ev0 = ev0; v.ec0 = ec0; v.ev1 = ev1; v.ec1 = ec1; v.em = em;
    return v;
  endfunction

  function automatic vec_t trn0(logic [31:0] pc, logic [31:0] a, logic [1:0] em);
    return mk(2'b00, 0, 0, 2'b01, pc, a, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, em);
  endfunction

  function automatic vec_t lkp0(logic [31:0] pc, logic eh, logic epv,
                                logic [31:0] ev, logic [2:0] ec);
    return mk(2'b01, pc, 0, 2'b00, 0, 0, 0, 0, 1'b0, {1'b0, eh}, {1'b0, epv},
              ev, ec, 0, 0, 2'b00);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(string ctx, logic [1:0] eh, epv, em,
                         logic [31:0] ev0, ev1, logic [2:0] ec0, ec1);
    check({ctx, " pred_hit"},   32'(bus.pred_hit),   32'(eh));
    check({ctx, " pred_valid"}, 32'(bus.pred_valid), 32'(epv));
    check({ctx, " trn_misp"},   32'(bus.trn_misp),   32'(em));
    check({ctx, " value0"},     bus.pred_value[0],   ev0);
    check({ctx, " value1"},     bus.pred_value[1],   ev1);
    check({ctx, " conf0"},      32'(bus.pred_conf[0]), 32'(ec0));
    check({ctx, " conf1"},      32'(bus.pred_conf[1]), 32'(ec1));
  endtask

  task automatic drive(logic [1:0] lv, logic [31:0] lp0, lp1, logic [1:0] tv,
                       logic [31:0] tp0, ta0, tp1, ta1, logic clr);
    bus.lkp_valid     = lv;
    bus.lkp_pc[0]     = lp0;
    bus.lkp_pc[1]     = lp1;
    bus.trn_valid     = tv;
    bus.trn_pc[0]     = tp0;
    bus.trn_actual[0] = ta0;
    bus.trn_pc[1]     = tp1;
    bus.trn_actual[1] = ta1;
    bus.clear         = clr;
  endtask

  // Expected next-cycle outputs from current inputs, then apply the update.
  task automatic model_step();
    int unsigned i;
    logic [31:0] pred, act;
    bit younger;
    x_hit = '0; x_pv = '0; x_misp = '0;
    for (int l = 0; l < LANES; l++) begin
      x_val[l] = '0; x_conf[l] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (bus.lkp_valid[l]) begin
        i = idx_of(bus.lkp_pc[l]);
        if (m_vld[i] && m_tag[i] == tag_of(bus.lkp_pc[l])) begin
          x_hit[l]  = 1'b1;
          x_val[l]  = m_val[i] + m_str[i];
          x_conf[l] = 3'(m_conf[i]);
          x_pv[l]   = (m_conf[i] >= CONF_THRESH);
        end
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (!bus.trn_valid[l]) continue;
      younger = 1'b0;
      for (int k = l + 1; k < LANES; k++)
        if (bus.trn_valid[k] && idx_of(bus.trn_pc[k]) == idx_of(bus.trn_pc[l]))
          younger = 1'b1;
      if (younger) continue;
      i    = idx_of(bus.trn_pc[l]);
      act  = bus.trn_actual[l];
      pred = m_val[i] + m_str[i];
      if (m_vld[i] && m_tag[i] == tag_of(bus.trn_pc[l])) begin
        if (pred == act) begin
          m_conf[i] = (m_conf[i] >= MAXC) ? MAXC : m_conf[i] + 1;
        end else begin
          x_misp[l] = (m_conf[i] >= CONF_THRESH);
          m_conf[i] = 0;
          if (STRIDE) m_str[i] = act - m_val[i];
        end
        m_val[i] = act;
      end else begin
        m_vld[i]  = 1'b1;
        m_tag[i]  = tag_of(bus.trn_pc[l]);
        m_val[i]  = act;
        m_conf[i] = 0;
        m_str[i]  = '0;
      end
    end
    if (bus.clear)
      for (int j = 0; j < DEPTH; j++) m_vld[j] = 1'b0;
  endtask

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) m_vld[j] = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) begin
      m_vld[j] = 1'b0; m_tag[j] = 0; m_val[j] = '0; m_str[j] = '0; m_conf[j] = 0;
    end
    drive(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0);

    // Allocation, threshold boundary, confident mispredict, tag alias.
    for (int n = 0; n < 4; n++) vecs.push_back(trn0(32'h100, 32'h55, 2'b00));
    vecs.push_back(lkp0(32'h100, 1'b1, 1'b0, 32'h55, 3'd3));
    vecs.push_back(trn0(32'h100, 32'h55, 2'b00));
    vecs.push_back(lkp0(32'h100, 1'b1, 1'b1, 32'h55, 3'd4));
    vecs.push_back(trn0(32'h100, 32'h66, 2'b01));
    vecs.push_back(mk(2'b11, 32'h100, 32'h180, 2'b00, 0, 0, 0, 0, 1'b0,
                      2'b01, 2'b00, E8V, 3'd0, 0, 3'd0, 2'b00));
    // Two lanes training the same index: only lane 1 writes.
    vecs.push_back(mk(2'b00, 0, 0, 2'b11, 32'h100, 32'h1, 32'h100, 32'h2, 1'b0,
                      2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(lkp0(32'h100, 1'b1, 1'b0, E10V, 3'd0));
    // Lookup and train same cycle: no bypass.
    vecs.push_back(mk(2'b01, 32'h100, 0, 2'b01, 32'h100, 32'h2, 0, 0, 1'b0,
                      2'b01, 2'b00, E10V, 3'd0, 0, 3'd0, 2'b00));
    vecs.push_back(lkp0(32'h100, 1'b1, 1'b0, 32'h2, E12C));
    // Saturation.
    for (int n = 0; n < 12; n++) vecs.push_back(trn0(32'h200, 32'h7, 2'b00));
    vecs.push_back(mk(2'b11, 32'h200, 32'h100, 2'b00, 0, 0, 0, 0, 1'b0,
                      2'b01, 2'b01, 32'h7, 3'd7, 0, 3'd0, 2'b00));
    // Clear with lookup, then clear with train.
    for (int n = 0; n < 8; n++) vecs.push_back(trn0(32'h300, 32'h33, 2'b00));
    vecs.push_back(mk(2'b01, 32'h300, 0, 2'b00, 0, 0, 0, 0, 1'b1,
                      2'b01, 2'b01, 32'h33, 3'd7, 0, 3'd0, 2'b00));
    vecs.push_back(lkp0(32'h300, 1'b0, 1'b0, 0, 3'd0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b01, 32'h300, 32'h33, 0, 0, 1'b1,
                      2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(lkp0(32'h300, 1'b0, 1'b0, 0, 3'd0));

    // Reset state.
    @(negedge clk); @(negedge clk);
    cmp_out("reset", 2'b00, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
    rst_l = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].lp0, vecs[i].lp1, vecs[i].tv, vecs[i].tp0,
            vecs[i].ta0, vecs[i].tp1, vecs[i].ta1, vecs[i].clr);
      model_step();
      @(posedge clk); #1;
      cmp_out($sformatf("vec%0d", i), vecs[i].eh, vecs[i].epv, vecs[i].em,
              vecs[i].ev0, vecs[i].ev1, vecs[i].ec0, vecs[i].ec1);
    end

    // Async reset in the middle of a hit.
    @(negedge clk);
    drive(2'b00, 0, 0, 2'b01, 32'h100, 32'h9, 0, 0, 1'b0);
    model_step();
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b01, 32'h100, 0, 2'b00, 0, 0, 0, 0, 1'b0);
    model_step();
    @(posedge clk); #1;
    cmp_out("rst_pre", 2'b01, 2'b00, 2'b00, 32'h9, 0, 3'd0, 3'd0);
    #2 rst_l = 1'b0;
    #1;
    cmp_out("rst_async", 2'b00, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    model_step();
    @(posedge clk); #1;
    cmp_out("rst_post", 2'b00, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);

    // Randomized traffic on a few indices/tags so hits, conflicts and saturation occur.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1),
            ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 1),
            32'($urandom_range(0, 2)),
            ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 1),
            32'($urandom_range(0, 2)),
            ($urandom_range(0, 63) == 0));
      model_step();
      @(posedge clk); #1;
      cmp_out($sformatf("rnd%0d", n), x_hit, x_pv, x_misp,
              x_val[0], x_val[1], x_conf[0], x_conf[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
